id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 13 +
 rtl/id_ex_hazard.sv | 27 ++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: bus/address range macros, NOP encoding, control-width default.
`ifndef ID_EX_STAGE_DEFINES_SV
`define ID_EX_STAGE_DEFINES_SV
`define DataBus      DATA_W-1:0
`define RegFileAddr  4:0
`define NopInst      32'h00000013
`define CtrlWDefault 16
`endif

package id_ex_stage_pkg;
    localparam logic [31:0] NOP_INST   = `NopInst;
    localparam int          CTRL_W_DEF = `CtrlWDefault;
endpackage

// File: rtl/id_ex_hazard.sv
// Load-use detector: ID reads a register that the load sitting in EX has not produced yet.
module id_ex_hazard
    import id_ex_stage_pkg::*;
(
    input  logic                i_id_vld,
    input  logic [`RegFileAddr] i_rs1_addr,
    input  logic                i_rs1_ren,
    input  logic [`RegFileAddr] i_rs2_addr,
    input  logic                i_rs2_ren,
    input  logic                i_ex_vld,
    input  logic                i_ex_mem_rd,
    input  logic                i_ex_rd_we,
    input  logic [`RegFileAddr] i_ex_rd_addr,
    output logic                o_hazard
);

    logic w_ex_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never blocks a consumer
    assign w_ex_load = i_ex_vld & i_ex_mem_rd & i_ex_rd_we & (i_ex_rd_addr != '0);
    assign w_rs1_hit = i_rs1_ren & (i_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit = i_rs2_ren & (i_rs2_addr == i_ex_rd_addr);
    assign o_hazard  = i_id_vld & w_ex_load & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: 1-cycle latency, holds while EX is busy, one bubble per load-use; flush beats everything.
// Optional ID_EX_PERF_CNT_EN adds wrapping bubble/stall counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IdValidIn,
    output logic                IdReadyOut,
    input  logic [`DataBus]     IdPcIn,
    input  logic [31:0]         IdInstIn,
    input  logic [`DataBus]     IdRs1DataIn,
    input  logic [`DataBus]     IdRs2DataIn,
    input  logic [`DataBus]     IdImmIn,
    input  logic [`RegFileAddr] IdRs1AddrIn,
    input  logic [`RegFileAddr] IdRs2AddrIn,
    input  logic                IdRs1ReadEnableIn,
    input  logic                IdRs2ReadEnableIn,
    input  logic [`RegFileAddr] IdRdAddrIn,
    input  logic                IdRdWriteEnableIn,
    input  logic                IdMemReadIn,
    input  logic [CTRL_W-1:0]   IdCtrlIn,
    input  logic                FlushIn,
    input  logic                ExReadyIn,
    output logic                ExValidOut,
    output logic [`DataBus]     ExPcOut,
    output logic [31:0]         ExInstOut,
    output logic [`DataBus]     ExRs1DataOut,
    output logic [`DataBus]     ExRs2DataOut,
    output logic [`DataBus]     ExImmOut,
    output logic [`RegFileAddr] ExRdAddrOut,
    output logic                ExRdWriteEnableOut,
    output logic                ExMemReadOut,
    output logic [CTRL_W-1:0]   ExCtrlOut,
    output logic                LoadUseStallOut
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]         BubbleCntOut,
    output logic [31:0]         StallCntOut
`endif
);

    logic                r_ex_vld;
    logic [`DataBus]     r_ex_pc;
    logic [31:0]         r_ex_inst;
    logic [`DataBus]     r_ex_rs1_dat;
    logic [`DataBus]     r_ex_rs2_dat;
    logic [`DataBus]     r_ex_imm;
    logic [`RegFileAddr] r_ex_rd_addr;
    logic                r_ex_rd_we;
    logic                r_ex_mem_rd;
    logic [CTRL_W-1:0]   r_ex_ctrl;

    logic w_advance;
    logic w_hazard;
    logic w_update;
    logic w_take;

    id_ex_hazard u_hazard (
        .i_id_vld     (IdValidIn),
        .i_rs1_addr   (IdRs1AddrIn),
        .i_rs1_ren    (IdRs1ReadEnableIn),
        .i_rs2_addr   (IdRs2AddrIn),
        .i_rs2_ren    (IdRs2ReadEnableIn),
        .i_ex_vld     (r_ex_vld),
        .i_ex_mem_rd  (r_ex_mem_rd),
        .i_ex_rd_we   (r_ex_rd_we),
        .i_ex_rd_addr (r_ex_rd_addr),
        .o_hazard     (w_hazard)
    );

    assign w_advance       = ExReadyIn | ~r_ex_vld;
    assign IdReadyOut      = FlushIn | (w_advance & ~w_hazard);
    assign LoadUseStallOut = w_hazard & ~FlushIn;

    // Reset and flush force a bubble even while EX is holding; otherwise only move on advance
    assign w_update = rst | FlushIn | w_advance;
    assign w_take   = ~rst & ~FlushIn & w_advance & IdValidIn & ~w_hazard;

    always_ff @(posedge clk) begin
        if (w_update) begin
            r_ex_vld     <= w_take;
            r_ex_pc      <= w_take ? IdPcIn            : '0;
            r_ex_inst    <= w_take ? IdInstIn          : NOP_INST;
            r_ex_rs1_dat <= w_take ? IdRs1DataIn       : '0;
            r_ex_rs2_dat <= w_take ? IdRs2DataIn       : '0;
            r_ex_imm     <= w_take ? IdImmIn           : '0;
            r_ex_rd_addr <= w_take ? IdRdAddrIn        : '0;
            r_ex_rd_we   <= w_take ? IdRdWriteEnableIn : 1'b0;
            r_ex_mem_rd  <= w_take ? IdMemReadIn       : 1'b0;
            r_ex_ctrl    <= w_take ? IdCtrlIn          : '0;
        end
    end

    assign ExValidOut         = r_ex_vld;
    assign ExPcOut            = r_ex_pc;
    assign ExInstOut          = r_ex_inst;
    assign ExRs1DataOut       = r_ex_rs1_dat;
    assign ExRs2DataOut       = r_ex_rs2_dat;
    assign ExImmOut           = r_ex_imm;
    assign ExRdAddrOut        = r_ex_rd_addr;
    assign ExRdWriteEnableOut = r_ex_rd_we;
    assign ExMemReadOut       = r_ex_mem_rd;
    assign ExCtrlOut          = r_ex_ctrl;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_bubble_evt;

    assign w_bubble_evt = ~FlushIn & w_advance & w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_bubble_evt) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (r_ex_vld & ~ExReadyIn) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign BubbleCntOut = r_bubble_cnt;
    assign StallCntOut  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/stall/flush/reset cases, then random traffic.
module tb_id_ex_stage;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          IdValidIn;
    logic          IdReadyOut;
    logic [DW-1:0] IdPcIn, IdRs1DataIn, IdRs2DataIn, IdImmIn;
    logic [31:0]   IdInstIn;
    logic [4:0]    IdRs1AddrIn, IdRs2AddrIn, IdRdAddrIn;
    logic          IdRs1ReadEnableIn, IdRs2ReadEnableIn, IdRdWriteEnableIn, IdMemReadIn;
    logic [CW-1:0] IdCtrlIn;
    logic          FlushIn, ExReadyIn;
    logic          ExValidOut;
    logic [DW-1:0] ExPcOut, ExRs1DataOut, ExRs2DataOut, ExImmOut;
    logic [31:0]   ExInstOut;
    logic [4:0]    ExRdAddrOut;
    logic          ExRdWriteEnableOut, ExMemReadOut;
    logic [CW-1:0] ExCtrlOut;
    logic          LoadUseStallOut;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   BubbleCntOut, StallCntOut;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IdValidIn(IdValidIn), .IdReadyOut(IdReadyOut),
        .IdPcIn(IdPcIn), .IdInstIn(IdInstIn),
        .IdRs1DataIn(IdRs1DataIn), .IdRs2DataIn(IdRs2DataIn), .IdImmIn(IdImmIn),
        .IdRs1AddrIn(IdRs1AddrIn), .IdRs2AddrIn(IdRs2AddrIn),
        .IdRs1ReadEnableIn(IdRs1ReadEnableIn), .IdRs2ReadEnableIn(IdRs2ReadEnableIn),
        .IdRdAddrIn(IdRdAddrIn), .IdRdWriteEnableIn(IdRdWriteEnableIn), .IdMemReadIn(IdMemReadIn),
        .IdCtrlIn(IdCtrlIn), .FlushIn(FlushIn), .ExReadyIn(ExReadyIn),
        .ExValidOut(ExValidOut), .ExPcOut(ExPcOut), .ExInstOut(ExInstOut),
        .ExRs1DataOut(ExRs1DataOut), .ExRs2DataOut(ExRs2DataOut), .ExImmOut(ExImmOut),
        .ExRdAddrOut(ExRdAddrOut), .ExRdWriteEnableOut(ExRdWriteEnableOut),
        .ExMemReadOut(ExMemReadOut), .ExCtrlOut(ExCtrlOut),
        .LoadUseStallOut(LoadUseStallOut)
`ifdef ID_EX_PERF_CNT_EN
        , .BubbleCntOut(BubbleCntOut), .StallCntOut(StallCntOut)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [31:0]   inst;
        logic [DW-1:0] rs1d;
        logic [DW-1:0] rs2d;
        logic [DW-1:0] imm;
        logic [CW-1:0] ctrl;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic          rs1en;
        logic          rs2en;
        logic          we;
        logic          mr;
    } instr_t;

    typedef struct {
        bit          known;
        logic        ex_valid;
        logic        id_ready;
        logic        stall;
        logic [31:0] bcnt;
        logic [31:0] scnt;
    } exp_t;

    // ex_q holds the instruction the reference pipeline has in EX (plus, briefly, its successor)
    instr_t      ex_q[$];
    exp_t        comb_q[$];
    bit          m_known = 1'b0;
    logic [31:0] m_bcnt = '0;
    logic [31:0] m_scnt = '0;
    int          n_checks = 0;
    int          n_fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t   e;
        instr_t h;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            if (e.known) begin
                chk("ex_valid", 64'(ExValidOut), 64'(e.ex_valid));
                chk("id_ready", 64'(IdReadyOut), 64'(e.id_ready));
                chk("load_use_stall", 64'(LoadUseStallOut), 64'(e.stall));
`ifdef ID_EX_PERF_CNT_EN
                chk("bubble_cnt", 64'(BubbleCntOut), 64'(e.bcnt));
                chk("stall_cnt", 64'(StallCntOut), 64'(e.scnt));
`endif
                if (e.ex_valid) begin
                    if (ex_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL ex_contents: got valid EX, expected instruction queue is empty at %0t", $time);
                    end else begin
                        h = ex_q[0];
                        chk("ex_pc", ExPcOut, h.pc);
                        chk("ex_inst", 64'(ExInstOut), 64'(h.inst));
                        chk("ex_rs1_data", ExRs1DataOut, h.rs1d);
                        chk("ex_rs2_data", ExRs2DataOut, h.rs2d);
                        chk("ex_imm", ExImmOut, h.imm);
                        chk("ex_ctrl", 64'(ExCtrlOut), 64'(h.ctrl));
                        chk("ex_rd", 64'(ExRdAddrOut), 64'(h.rd));
                        chk("ex_rd_we", 64'(ExRdWriteEnableOut), 64'(h.we));
                        chk("ex_mem_rd", 64'(ExMemReadOut), 64'(h.mr));
                        if ((ExReadyIn || FlushIn) && !rst) begin
                            void'(ex_q.pop_front());
                        end
                    end
                end else begin
                    chk("bubble_inst", 64'(ExInstOut), 64'h13);
                    chk("bubble_pc", ExPcOut, 64'h0);
                    chk("bubble_rs1_data", ExRs1DataOut, 64'h0);
                    chk("bubble_imm", ExImmOut, 64'h0);
                    chk("bubble_rd_we", 64'(ExRdWriteEnableOut), 64'h0);
                    chk("bubble_mem_rd", 64'(ExMemReadOut), 64'h0);
                    chk("bubble_ctrl", 64'(ExCtrlOut), 64'h0);
                end
            end
        end
    end

    function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic e1,
                                  input logic [4:0] rs2, input logic e2, input logic we, input logic mr);
        instr_t i;
        i.pc    = {$urandom, $urandom};
        i.inst  = $urandom;
        i.rs1d  = {$urandom, $urandom};
        i.rs2d  = {$urandom, $urandom};
        i.imm   = {$urandom, $urandom};
        i.ctrl  = CW'($urandom);
        i.rs1   = rs1;
        i.rs2   = rs2;
        i.rd    = rd;
        i.rs1en = e1;
        i.rs2en = e2;
        i.we    = we;
        i.mr    = mr;
        return i;
    endfunction

    // One clock cycle: drive, predict from the reference EX contents, then advance the reference
    task automatic step(input instr_t ins, input logic vld, input logic flush,
                        input logic exrdy, input logic rs);
        exp_t   e;
        logic   occupied, hz, adv, take;
        instr_t cur;
        IdValidIn = vld;   IdPcIn = ins.pc;   IdInstIn = ins.inst;
        IdRs1DataIn = ins.rs1d; IdRs2DataIn = ins.rs2d; IdImmIn = ins.imm;
        IdRs1AddrIn = ins.rs1;  IdRs2AddrIn = ins.rs2;  IdRdAddrIn = ins.rd;
        IdRs1ReadEnableIn = ins.rs1en; IdRs2ReadEnableIn = ins.rs2en;
        IdRdWriteEnableIn = ins.we;    IdMemReadIn = ins.mr;  IdCtrlIn = ins.ctrl;
        FlushIn = flush;   ExReadyIn = exrdy;  rst = rs;

        occupied = (ex_q.size() != 0);
        hz = 1'b0;
        if (occupied) begin
            cur = ex_q[0];
            hz = vld && cur.mr && cur.we && (cur.rd != 5'd0) &&
                 ((ins.rs1en && ins.rs1 == cur.rd) || (ins.rs2en && ins.rs2 == cur.rd));
        end
        adv        = exrdy || !occupied;
        e.known    = m_known;
        e.ex_valid = occupied;
        e.id_ready = flush || (adv && !hz);
        e.stall    = hz && !flush;
        e.bcnt     = m_bcnt;
        e.scnt     = m_scnt;
        comb_q.push_back(e);
        take = !rs && !flush && adv && vld && !hz;
        if (take) ex_q.push_back(ins);

        @(posedge clk);
        #1;
        if (rs) begin
            m_known = 1'b1;
            ex_q.delete();
            m_bcnt = '0;
            m_scnt = '0;
        end else begin
            if (!flush && adv && hz) m_bcnt = m_bcnt + 32'd1;
            if (occupied && !exrdy)  m_scnt = m_scnt + 32'd1;
        end
    endtask

    initial begin
        instr_t lw5, add6, add7, idle, lw0, addx0, add_rs2off;
        rst = 1'b1; IdValidIn = 1'b0; FlushIn = 1'b0; ExReadyIn = 1'b1;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step(idle, 1'b0, 1'b0, 1'b1, 1'b1);

        // lw x5 ; add x6,x5,x1 -> one bubble, add arrives one cycle late
        lw5  = mk(5, 2, 1, 0, 0, 1, 1);
        add6 = mk(6, 5, 1, 1, 1, 1, 0);
        step(lw5,  1'b1, 1'b0, 1'b1, 1'b0);
        step(add6, 1'b1, 1'b0, 1'b1, 1'b0);
        step(add6, 1'b1, 1'b0, 1'b1, 1'b0);

        // lw x0 ; add x6,x0,x1 -> no hazard
        lw0   = mk(0, 2, 1, 0, 0, 1, 1);
        addx0 = mk(6, 0, 1, 1, 1, 1, 0);
        step(lw0,   1'b1, 1'b0, 1'b1, 1'b0);
        step(addx0, 1'b1, 1'b0, 1'b1, 1'b0);

        // EX busy for three cycles with an add held
        add7 = mk(7, 1, 1, 2, 1, 1, 0);
        step(add7, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(add6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(add6, 1'b1, 1'b0, 1'b1, 1'b0);

        // flush with EX busy and a pending load-use
        step(lw5,  1'b1, 1'b0, 1'b1, 1'b0);
        step(add6, 1'b1, 1'b1, 1'b0, 1'b0);
        step(idle, 1'b0, 1'b0, 1'b1, 1'b0);

        // reset in the middle of a stall
        step(add7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(add6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(add6, 1'b1, 1'b0, 1'b0, 1'b1);
        step(idle, 1'b0, 1'b0, 1'b1, 1'b0);

        // rs2 field matches the load's rd but is not read
        add_rs2off = mk(6, 1, 1, 5, 0, 1, 0);
        step(lw5,        1'b1, 1'b0, 1'b1, 1'b0);
        step(add_rs2off, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            instr_t r;
            r = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) < 8),
                   ($urandom_range(0, 9) < 4));
            step(r, ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        step(idle, 1'b0, 1'b0, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
